// File: rtl/jarch_pkg.sv
// Shared fetch-path widths, FSM state type and FIFO entry layout.
package jarch_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
// Latency: a push is visible at the head the cycle after; head holds its last value when empty.
// Backpressure: full is reported; push while full is accepted only together with a pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             push_en;
    logic             pop_en;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign pop_en   = pop && !empty && !flush;
    assign push_en  = push && (!full || pop_en) && !flush;
    // When empty, the head keeps showing the last entry that sat there.
    assign head_dat = empty ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = head_dat;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: sequential req/ack reads from program memory, buffered for decode.
// Latency: word acked in cycle N is valid to decode in N+1; redirect from idle requests in 1 cycle.
// Backpressure: no new request unless the FIFO has room counting the in-flight word.
module instr_fetch_unit
    import jarch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              init_flag,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NXT_W = CNT_W + 1;
    localparam logic [NXT_W-1:0] DEPTH_N = NXT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [NXT_W-1:0]  cnt_nxt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              room;
    fetch_entry_t      push_ent;
    fetch_entry_t      head_ent;

    assign mem_req     = (state_q != IDLE);
    assign mem_addr    = mem_addr_q;
    assign fetch_pc    = fetch_pc_q;
    assign instr_valid = !fifo_empty;
    assign instr_data  = head_ent.instr;
    assign instr_pc    = head_ent.pc;

    assign pop      = instr_valid && instr_ready && !redirect;
    assign push     = (state_q == REQ) && mem_ack && !redirect && (!fifo_full || pop);
    assign push_ent = '{pc: mem_addr_q, instr: mem_rdata};

    // Occupancy after this cycle's push/pop/flush decides whether another word may be requested.
    always_comb begin
        cnt_nxt = {1'b0, fifo_cnt};
        if (redirect) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = {1'b0, fifo_cnt} + NXT_W'(push) - NXT_W'(pop);
        end
    end

    assign room = init_flag && (cnt_nxt < DEPTH_N);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (room) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = (room && !redirect) ? REQ : IDLE;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
    end

    // The address is captured when a request is launched and held until its ack, even across a redirect.
    always_comb begin
        mem_addr_d = mem_addr_q;
        if (state_d == REQ) begin
            mem_addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (redirect),
        .head_dat (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_unit;
    import jarch_pkg::*;

    localparam int DEPTH = 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              init_flag = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] fetch_pc;

    int checks = 0;
    int errors = 0;
    int min_wait = 0;
    int max_wait = 0;
    int wait_left = 0;
    bit req_active = 0;

    // Model state: expected FIFO contents and fetch address
    logic [ADDR_W-1:0] q_pc[$];
    logic [DATA_W-1:0] q_dat[$];
    logic [ADDR_W-1:0] m_fetch = '0;
    logic [ADDR_W-1:0] held_addr = '0;
    logic [ADDR_W-1:0] last_pc = '0;
    logic [DATA_W-1:0] last_dat = '0;
    bit drop_pend = 0;
    bit prev_hold = 0;
    bit exp_req = 0;
    int n_pops = 0;

    always #5 clock = ~clock;

    instr_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .init_flag   (init_flag),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .fetch_pc    (fetch_pc)
    );

    task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Program memory: each word encodes its own address so data can be cross-checked.
    task automatic drive_mem();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
            if (!req_active) begin
                req_active = 1;
                wait_left  = (min_wait == max_wait) ? min_wait : $urandom_range(max_wait, min_wait);
            end
            if (wait_left == 0) begin
                mem_ack    = 1'b1;
                mem_rdata  = {mem_addr ^ 16'hC3A5, mem_addr};
                req_active = 0;
            end else begin
                wait_left--;
            end
        end
    endtask

    task automatic cyc();
        drive_mem();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        init_flag   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        mem_ack     = 1'b0;
        req_active  = 0;
        min_wait    = 0;
        max_wait    = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clock) begin : model
        bit was_drop;
        bit push;
        bit pop;
        if (!reset_n) begin
            q_pc.delete();
            q_dat.delete();
            m_fetch   = '0;
            drop_pend = 0;
            prev_hold = 0;
            exp_req   = 0;
            last_pc   = '0;
            last_dat  = '0;
        end else begin
            chk("mem_req", mem_req, exp_req);
            chk("fetch_pc", fetch_pc, m_fetch);
            chk("instr_valid", instr_valid, q_pc.size() != 0);
            if (q_pc.size() != 0) begin
                chk("head_pc", instr_pc, q_pc[0]);
                chk("head_data", instr_data, q_dat[0]);
            end else begin
                chk("hold_pc", instr_pc, last_pc);
                chk("hold_data", instr_data, last_dat);
            end
            if (mem_req && prev_hold)
                chk("addr_stable", mem_addr, held_addr);
            else if (mem_req)
                chk("req_addr", mem_addr, m_fetch);

            was_drop = drop_pend;
            pop  = instr_valid && instr_ready && !redirect;
            push = mem_req && mem_ack && !drop_pend && !redirect;
            if (q_pc.size() != 0) begin
                last_pc  = q_pc[0];
                last_dat = q_dat[0];
            end
            if (pop && q_pc.size() != 0) begin
                void'(q_pc.pop_front());
                void'(q_dat.pop_front());
                n_pops++;
            end
            if (push) begin
                q_pc.push_back(m_fetch);
                q_dat.push_back(mem_rdata);
                m_fetch = m_fetch + 16'd1;
            end
            if (redirect) begin
                q_pc.delete();
                q_dat.delete();
                m_fetch = redirect_pc;
            end
            if (mem_req && mem_ack)
                drop_pend = 0;
            else if (mem_req && redirect)
                drop_pend = 1;
            prev_hold = mem_req && !mem_ack;
            held_addr = mem_addr;
            if (mem_req && !mem_ack)
                exp_req = 1;
            else if (mem_req && (redirect || was_drop))
                exp_req = 0;
            else
                exp_req = init_flag && (q_pc.size() < DEPTH);
        end
    end

    initial begin
        // Reset in the middle of an outstanding request
        do_reset();
        init_flag = 1'b1;
        min_wait  = 5;
        max_wait  = 5;
        cyc();
        chk("pre_reset_req", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_fetch_pc", fetch_pc, 16'h0000);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_data", instr_data, 32'h0);
        chk("rst_pc", instr_pc, 16'h0000);
        @(posedge clock);
        #1;
        init_flag  = 1'b0;
        mem_ack    = 1'b0;
        req_active = 0;
        min_wait   = 0;
        max_wait   = 0;
        reset_n    = 1'b1;
        cyc();
        chk("rel_mem_req", mem_req, 1'b0);
        chk("rel_valid", instr_valid, 1'b0);
        chk("rel_fetch_pc", fetch_pc, 16'h0000);

        // Zero-wait streaming: 2-cycle lead then one word per cycle
        init_flag   = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("stream_valid", instr_valid, k >= 2);
            if (k == 1) chk("stream_req", mem_req, 1'b1);
            if (k >= 2) chk("stream_pc", instr_pc, 16'(k - 2));
            cyc();
        end

        // Decode stalled: FIFO fills to DEPTH and requests stop
        do_reset();
        init_flag = 1'b1;
        repeat (6) cyc();
        chk("full_valid", instr_valid, 1'b1);
        chk("full_pc", instr_pc, 16'h0000);
        chk("full_req", mem_req, 1'b0);
        chk("full_fetch_pc", fetch_pc, 16'h0002);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("release_pc", instr_pc, 16'h0001);
        chk("release_req", mem_req, 1'b1);
        chk("release_addr", mem_addr, 16'h0002);

        // Redirect while a request waits for a slow ack
        do_reset();
        init_flag   = 1'b1;
        instr_ready = 1'b1;
        min_wait    = 3;
        max_wait    = 3;
        cyc();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        cyc();
        redirect = 1'b0;
        chk("drop_req", mem_req, 1'b1);
        chk("drop_addr", mem_addr, 16'h0000);
        chk("drop_fetch_pc", fetch_pc, 16'h0040);
        min_wait = 0;
        max_wait = 0;
        cyc();
        cyc();
        chk("drop_done_req", mem_req, 1'b0);
        chk("drop_done_valid", instr_valid, 1'b0);
        cyc();
        chk("redir_req", mem_req, 1'b1);
        chk("redir_addr", mem_addr, 16'h0040);
        cyc();
        chk("redir_valid", instr_valid, 1'b1);
        chk("redir_pc", instr_pc, 16'h0040);

        // Fetch address wraps from FFFF to 0
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        cyc();
        redirect = 1'b0;
        chk("wrap_pre_fetch", fetch_pc, 16'hFFFF);
        chk("wrap_pre_req", mem_req, 1'b0);
        init_flag = 1'b1;
        cyc();
        chk("wrap_req_addr", mem_addr, 16'hFFFF);
        cyc();
        chk("wrap_fetch_pc", fetch_pc, 16'h0000);
        chk("wrap_valid", instr_valid, 1'b1);
        chk("wrap_pc", instr_pc, 16'hFFFF);
        chk("wrap_data", instr_data, 32'h3C5AFFFF);
        init_flag = 1'b0;

        // Redirect coincident with ack while one word is buffered
        do_reset();
        init_flag = 1'b1;
        cyc();
        cyc();
        chk("coinc_pre_valid", instr_valid, 1'b1);
        chk("coinc_pre_req", mem_req, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        cyc();
        redirect = 1'b0;
        chk("coinc_valid", instr_valid, 1'b0);
        chk("coinc_req", mem_req, 1'b0);
        chk("coinc_fetch_pc", fetch_pc, 16'h0080);
        cyc();
        chk("coinc_next_addr", mem_addr, 16'h0080);

        // Random traffic against the model
        do_reset();
        n_pops = 0;
        for (int i = 0; i < 4000; i++) begin
            init_flag   = ($urandom_range(7, 0) != 0);
            instr_ready = ((i / 500) % 2 == 0) ? ($urandom_range(3, 0) != 0)
                                               : ($urandom_range(3, 0) == 0);
            redirect    = ($urandom_range(29, 0) == 0);
            redirect_pc = ($urandom_range(3, 0) == 0) ? 16'hFFFF - 16'($urandom_range(2, 0))
                                                      : 16'($urandom);
            min_wait    = 0;
            max_wait    = ((i / 1000) % 2 == 1) ? 3 : 0;
            cyc();
        end
        redirect  = 1'b0;
        init_flag = 1'b0;
        cyc();
        chk("progress", n_pops > 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
